// File: rtl/rd53a_cmd_framer.sv
// RD53A command-stream framer: power-up SYNC burst, periodic SYNC insertion,
// NOOP idle fill, and MSB-first serialization at one bit per clock.
module rd53a_cmd_framer #(
  parameter int unsigned SYNC_PERIOD = 32,
  parameter int unsigned INIT_SYNC   = 32,
  parameter logic [15:0] SYNC_WORD   = 16'h817E,
  parameter logic [15:0] NOOP_WORD   = 16'h6969
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        cmd_o,
  output logic        frame_start,
  output logic        init_done,
  output logic [15:0] sync_cnt,
  output logic [15:0] data_cnt,
  output logic        state_dbg
);

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;

  localparam logic [7:0] GAP_MAX   = 8'(SYNC_PERIOD - 1);
  localparam logic [7:0] INIT_LAST = 8'(INIT_SYNC - 1);

  state_e      state_q, state_d;
  logic [15:0] sreg_q, sreg_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  init_cnt_q, init_cnt_d;
  logic [7:0]  gap_cnt_q, gap_cnt_d;
  logic        cmd_q, cmd_d;
  logic        frame_start_q, frame_start_d;
  logic        init_done_q, init_done_d;
  logic [15:0] sync_cnt_q, sync_cnt_d;
  logic [15:0] data_cnt_q, data_cnt_d;
  logic        sync_first_q, sync_first_d;
  logic        load_slot;

  // Handshake: a word transfers on any cycle with s_valid && s_ready. s_ready
  // never looks at s_valid and is only high in the load slot of a non-SYNC
  // frame; the scheduler holds s_data stable while s_valid && !s_ready.
  assign load_slot = (bit_cnt_q == 4'd15);
  assign s_ready   = load_slot && (state_q == ST_RUN) && (gap_cnt_q != GAP_MAX);

  always_comb begin
    state_d       = state_q;
    sreg_d        = {sreg_q[14:0], 1'b0};
    bit_cnt_d     = bit_cnt_q + 4'd1;
    init_cnt_d    = init_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    cmd_d         = sreg_q[15];
    frame_start_d = (bit_cnt_q == 4'd0);
    init_done_d   = init_done_q;
    sync_cnt_d    = sync_cnt_q;
    data_cnt_d    = data_cnt_q;
    sync_first_d  = 1'b0;

    // The SYNC preloaded by reset is counted on the first edge after release.
    if (sync_first_q) begin
      sync_cnt_d = sync_cnt_q + 16'd1;
    end

    if (load_slot) begin
      if (state_q == ST_INIT) begin
        sreg_d     = SYNC_WORD;
        sync_cnt_d = sync_cnt_q + 16'd1;
        init_cnt_d = init_cnt_q + 8'd1;
        gap_cnt_d  = 8'd0;
        if (init_cnt_q >= INIT_LAST) begin
          state_d     = ST_RUN;
          init_done_d = 1'b1;
        end
      end else if (gap_cnt_q == GAP_MAX) begin
        sreg_d     = SYNC_WORD;
        sync_cnt_d = sync_cnt_q + 16'd1;
        gap_cnt_d  = 8'd0;
      end else if (s_valid) begin
        sreg_d     = s_data;
        data_cnt_d = data_cnt_q + 16'd1;
        gap_cnt_d  = gap_cnt_q + 8'd1;
      end else begin
        sreg_d    = NOOP_WORD;
        gap_cnt_d = gap_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_INIT;
      sreg_q        <= SYNC_WORD;
      bit_cnt_q     <= 4'd0;
      init_cnt_q    <= 8'd1;
      gap_cnt_q     <= 8'd0;
      cmd_q         <= 1'b0;
      frame_start_q <= 1'b0;
      init_done_q   <= 1'b0;
      sync_cnt_q    <= 16'd0;
      data_cnt_q    <= 16'd0;
      sync_first_q  <= 1'b1;
    end else begin
      state_q       <= state_d;
      sreg_q        <= sreg_d;
      bit_cnt_q     <= bit_cnt_d;
      init_cnt_q    <= init_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      cmd_q         <= cmd_d;
      frame_start_q <= frame_start_d;
      init_done_q   <= init_done_d;
      sync_cnt_q    <= sync_cnt_d;
      data_cnt_q    <= data_cnt_d;
      sync_first_q  <= sync_first_d;
    end
  end

  assign cmd_o       = cmd_q;
  assign frame_start = frame_start_q;
  assign init_done   = init_done_q;
  assign sync_cnt    = sync_cnt_q;
  assign data_cnt    = data_cnt_q;
  assign state_dbg   = (state_q == ST_RUN);

endmodule

// File: tb/tb_rd53a_cmd_framer.sv
// Bench for rd53a_cmd_framer: a frame-level model pushes expected frames at each
// load slot; a deserializer pops and compares every completed frame.
module tb_rd53a_cmd_framer;

  localparam int          SP   = 32;
  localparam int          IS   = 32;
  localparam logic [15:0] SYNC = 16'h817E;
  localparam logic [15:0] NOOP = 16'h6969;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] s_data = 16'h0000;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        cmd_o;
  logic        frame_start;
  logic        init_done;
  logic [15:0] sync_cnt;
  logic [15:0] data_cnt;
  logic        state_dbg;

  rd53a_cmd_framer #(
    .SYNC_PERIOD(SP),
    .INIT_SYNC  (IS),
    .SYNC_WORD  (SYNC),
    .NOOP_WORD  (NOOP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .cmd_o      (cmd_o),
    .frame_start(frame_start),
    .init_done  (init_done),
    .sync_cnt   (sync_cnt),
    .data_cnt   (data_cnt),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] exp_q[$];

  // frame-level reference model
  int          m_init_left;
  int          m_gap;
  logic [15:0] m_sync;
  logic [15:0] m_data;
  logic        m_init_done;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // scoreboard: deserialize cmd_o and compare each finished frame
  logic [15:0] mon_sh = 16'h0;
  int          mon_nb = 0;
  logic        mon_coll = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      mon_coll = 1'b0;
      mon_nb   = 0;
    end else begin
      if (frame_start) begin
        mon_sh   = {15'b0, cmd_o};
        mon_nb   = 1;
        mon_coll = 1'b1;
      end else if (mon_coll) begin
        mon_sh = {mon_sh[14:0], cmd_o};
        mon_nb++;
      end
      if (mon_coll && mon_nb == 16) begin
        if (exp_q.size() == 0) begin
          chk("frame_unexpected", 32'(exp_q.size()), 32'd1);
        end else begin
          chk("frame", 32'(mon_sh), 32'(exp_q.pop_front()));
        end
        mon_coll = 1'b0;
      end
    end
  end

  task automatic model_slot(input logic v, input logic [15:0] d, output logic er);
    er = (m_init_left == 0) && (m_gap != SP - 1);
    if (m_init_left > 0) begin
      exp_q.push_back(SYNC);
      m_init_left--;
      m_sync++;
      m_gap = 0;
      if (m_init_left == 0) m_init_done = 1'b1;
    end else if (m_gap == SP - 1) begin
      exp_q.push_back(SYNC);
      m_sync++;
      m_gap = 0;
    end else if (v) begin
      exp_q.push_back(d);
      m_data++;
      m_gap++;
    end else begin
      exp_q.push_back(NOOP);
      m_gap++;
    end
  endtask

  // driver: rst is expected high on entry; holds it for n edges and releases
  task automatic do_reset(input int n);
    rst     = 1'b1;
    s_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    chk("rst_cmd_o", 32'(cmd_o), 32'd0);
    chk("rst_frame_start", 32'(frame_start), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_sync_cnt", 32'(sync_cnt), 32'd0);
    chk("rst_data_cnt", 32'(data_cnt), 32'd0);
    chk("rst_state", 32'(state_dbg), 32'd0);
    rst = 1'b0;
    exp_q.delete();
    m_init_left = IS - 1;
    m_gap       = 0;
    m_sync      = 16'd1;
    m_data      = 16'd0;
    m_init_done = 1'b0;
    exp_q.push_back(SYNC);
  endtask

  // driver: one 16-cycle frame period, load slot in the last cycle
  task automatic run_frame(input logic v, input logic [15:0] d, output logic acc);
    logic er;
    s_valid = v;
    s_data  = d;
    for (int c = 1; c <= 15; c++) begin
      @(posedge clk);
      #1;
      chk("frame_start", 32'(frame_start), 32'(c == 1));
      if (c < 15) chk("s_ready_idle", 32'(s_ready), 32'd0);
    end
    model_slot(v, d, er);
    chk("s_ready_slot", 32'(s_ready), 32'(er));
    acc = v && s_ready;
    @(posedge clk);
    #1;
    chk("frame_start_end", 32'(frame_start), 32'd0);
    chk("init_done", 32'(init_done), 32'(m_init_done));
    chk("state", 32'(state_dbg), 32'(m_init_done));
    chk("sync_cnt", 32'(sync_cnt), 32'(m_sync));
    chk("data_cnt", 32'(data_cnt), 32'(m_data));
  endtask

  initial begin
    logic        acc;
    logic [15:0] d;
    logic [15:0] dc0;
    int          xfers;
    int          guard;

    // reset, then 34 idle frame times: SYNC burst followed by NOOPs
    do_reset(3);
    for (int i = 0; i < 34; i++) run_frame(1'b0, 16'h0000, acc);
    chk("init_done_after_burst", 32'(init_done), 32'd1);
    chk("sync_cnt_after_burst", 32'(sync_cnt), 32'd32);

    // single held word
    run_frame(1'b1, 16'hA5C3, acc);
    chk("single_accept", 32'(acc), 32'd1);
    run_frame(1'b0, 16'h0000, acc);
    chk("single_data_cnt", 32'(data_cnt), 32'd1);

    // continuous incrementing stream across SYNC insertions
    d     = 16'h1000;
    dc0   = data_cnt;
    xfers = 0;
    for (int i = 0; i < 70; i++) begin
      run_frame(1'b1, d, acc);
      if (acc) begin
        d++;
        xfers++;
      end
    end
    chk("stream_xfers", 32'(data_cnt - dc0), 32'(xfers));
    chk("stream_words", 32'(d - 16'h1000), 32'(xfers));

    // valid first presented in the forced-SYNC slot
    guard = 0;
    while (m_gap != SP - 1 && guard < 40) begin
      run_frame(1'b0, 16'h0000, acc);
      guard++;
    end
    chk("reach_gap_max", 32'(m_gap), 32'(SP - 1));
    run_frame(1'b1, 16'hBEEF, acc);
    chk("deferred_at_sync", 32'(acc), 32'd0);
    run_frame(1'b1, 16'hBEEF, acc);
    chk("deferred_accept", 32'(acc), 32'd1);

    // reset pulse while bit 7 of a data frame would be driven
    run_frame(1'b1, 16'h1234, acc);
    s_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    do_reset(1);
    for (int i = 0; i < 33; i++) run_frame(1'b0, 16'h0000, acc);
    chk("reinit_done", 32'(init_done), 32'd1);

    // long idle in RUN with random unused data on the bus
    for (int i = 0; i < 100; i++) run_frame(1'b0, 16'($urandom_range(0, 65535)), acc);

    @(negedge clk);
    #1;
    chk("drain", 32'(exp_q.size()), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
